// File: rtl/irq_ctrl_if.sv
// CPU data/IO bus view of the interrupt controller register file.
// The CPU drives address and strobes; the controller returns read data.
interface irq_ctrl_if;
  logic [15:0] addr_i;
  logic [7:0]  wr_data_i;
  logic        wr_en_i;
  logic        rd_en_i;
  logic [7:0]  rd_data_o;

  modport master (
    output addr_i,
    output wr_data_i,
    output wr_en_i,
    output rd_en_i,
    input  rd_data_o
  );

  modport slave (
    input  addr_i,
    input  wr_data_i,
    input  wr_en_i,
    input  rd_en_i,
    output rd_data_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: syncs raw sources, latches edge/level pending bits,
// masks them and drives registered request lines to the CPU.
module irq_ctrl #(
  parameter int          N_SRC     = 3,
  parameter logic [15:0] BASE_ADDR = 16'hFF10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_i,
  irq_ctrl_if.slave        bus,
  output logic [N_SRC-1:0] irq_o
);

  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] ie, ip, im;
  logic [N_SRC-1:0] rise, setV, clrV;
  logic [15:0]      off;
  logic             hit;
  logic             wrIe, wrIp, wrIm;
  logic [7:0]       regVal;
  logic [7:0]       rdData;

  assign rise = s2 & ~s3;
  assign setV = (im & rise) | (~im & s2);

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range too
  assign off = bus.addr_i - BASE_ADDR;
  assign hit = (off < 16'd4);

  assign wrIe = bus.wr_en_i && hit && (off[1:0] == 2'd0);
  assign wrIp = bus.wr_en_i && hit && (off[1:0] == 2'd1);
  assign wrIm = bus.wr_en_i && hit && (off[1:0] == 2'd2);

  assign clrV = wrIp ? bus.wr_data_i[N_SRC-1:0] : '0;

  always_comb begin
    regVal = '0;
    case (off[1:0])
      2'd0:    regVal[N_SRC-1:0] = ie;
      2'd1:    regVal[N_SRC-1:0] = ip;
      2'd2:    regVal[N_SRC-1:0] = im;
      default: regVal[N_SRC-1:0] = s2;
    endcase
  end

  assign rdData = (bus.rd_en_i && hit) ? regVal : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      ie    <= '0;
      ip    <= '0;
      im    <= '0;
      irq_o <= '0;
      bus.rd_data_o <= '0;
    end else begin
      s1 <= src_i;
      s2 <= s1;
      s3 <= s2;
      // Set wins: a held level or fresh edge survives a same-cycle clear
      ip <= setV | (ip & ~clrV);
      if (wrIe) ie <= bus.wr_data_i[N_SRC-1:0];
      if (wrIm) im <= bus.wr_data_i[N_SRC-1:0];
      irq_o <= ip & ie;
      bus.rd_data_o <= rdData;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: reset, edge/level pending, masking,
// set-vs-clear race, bus decode and async reset.
module tb_irq_ctrl;

  localparam logic [15:0] BASE = 16'hFF10;

  logic       clk;
  logic       rst_n;
  logic [2:0] src;
  logic [2:0] irq;
  logic [7:0] rv;
  int         nChecks;
  int         nPass;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .N_SRC(3),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_i(src),
    .bus(bus),
    .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  task automatic wrA(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.addr_i = a;
    bus.wr_data_i = d;
    bus.wr_en_i = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d);
    wrA(BASE + 16'(o), d);
  endtask

  task automatic rdA(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.addr_i = a;
    bus.rd_en_i = 1'b1;
    @(negedge clk);
    bus.rd_en_i = 1'b0;
    d = bus.rd_data_o;
  endtask

  task automatic rd(input logic [1:0] o, output logic [7:0] d);
    rdA(BASE + 16'(o), d);
  endtask

  initial begin
    nChecks = 0;
    nPass = 0;
    bus.addr_i = '0;
    bus.wr_data_i = '0;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    rst_n = 1'b0;
    src = 3'b111;

    // Reset held with sources active
    repeat (5) @(negedge clk);
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_rd", bus.rd_data_o, 8'h00);
    src = 3'b000;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd(2'd1, rv);
    chk("rst_ip", rv, 8'h00);

    // Edge mode on source 0
    wr(2'd2, 8'h01);
    wr(2'd0, 8'h01);
    @(negedge clk);
    src[0] = 1'b1;
    @(posedge clk);
    #1 src[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("edge_e3", 8'(irq), 8'h00);
    @(posedge clk);
    #1 chk("edge_e4", 8'(irq), 8'h01);
    repeat (3) @(posedge clk);
    #1 chk("edge_hold", 8'(irq), 8'h01);
    wr(2'd1, 8'h01);
    chk("w1c_ew", 8'(irq), 8'h01);
    @(negedge clk);
    chk("w1c_ew1", 8'(irq), 8'h00);
    rd(2'd1, rv);
    chk("w1c_ip", rv, 8'h00);

    // Level mode on source 1, held high
    wr(2'd2, 8'h00);
    wr(2'd0, 8'h02);
    src[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("lvl_irq", 8'(irq), 8'h02);
    wr(2'd1, 8'h02);
    rd(2'd1, rv);
    chk("lvl_ip_held", rv, 8'h02);
    chk("lvl_irq_held", 8'(irq), 8'h02);
    src[1] = 1'b0;
    repeat (4) @(negedge clk);
    wr(2'd1, 8'h02);
    rd(2'd1, rv);
    chk("lvl_ip_clr", rv, 8'h00);

    // Masking on source 2 (edge mode)
    wr(2'd0, 8'h00);
    wr(2'd2, 8'h04);
    src[2] = 1'b1;
    repeat (5) @(negedge clk);
    src[2] = 1'b0;
    rd(2'd1, rv);
    chk("mask_ip", rv, 8'h04);
    chk("mask_irq", 8'(irq), 8'h00);
    wr(2'd0, 8'h04);
    chk("unmask_ew", 8'(irq), 8'h00);
    @(negedge clk);
    chk("unmask_ew1", 8'(irq), 8'h04);
    wr(2'd1, 8'h04);
    wr(2'd0, 8'h00);

    // Rise reaches IP on the same edge as the W1C
    wr(2'd2, 8'h01);
    wr(2'd0, 8'h01);
    src[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.addr_i = BASE + 16'd1;
    bus.wr_data_i = 8'h01;
    bus.wr_en_i = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    rd(2'd1, rv);
    chk("race_ip", rv, 8'h01);
    chk("race_irq", 8'(irq), 8'h01);
    src[0] = 1'b0;
    wr(2'd1, 8'h01);

    // Bus decode
    wr(2'd0, 8'h05);
    wr(2'd2, 8'h03);
    src[2] = 1'b1;
    repeat (4) @(negedge clk);
    src[2] = 1'b0;
    repeat (4) @(negedge clk);
    wrA(BASE + 16'd4, 8'hFF);
    wrA(BASE - 16'd1, 8'hFF);
    rd(2'd0, rv);
    chk("dec_ie", rv, 8'h05);
    rd(2'd1, rv);
    chk("dec_ip", rv, 8'h04);
    rd(2'd2, rv);
    chk("dec_im", rv, 8'h03);
    rdA(BASE + 16'd4, rv);
    chk("dec_oor_rd", rv, 8'h00);
    src = 3'b101;
    repeat (4) @(negedge clk);
    rd(2'd3, rv);
    chk("raw", rv, 8'h05);

    // Same-cycle read and write of IE returns the old value
    @(negedge clk);
    bus.addr_i = BASE;
    bus.wr_data_i = 8'h01;
    bus.wr_en_i = 1'b1;
    bus.rd_en_i = 1'b1;
    @(negedge clk);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    chk("rw_same", bus.rd_data_o, 8'h05);
    rd(2'd0, rv);
    chk("rw_after", rv, 8'h01);

    // Async reset drops irq mid-cycle
    repeat (2) @(negedge clk);
    chk("pre_arst", 8'(irq), 8'h01);
    #2 rst_n = 1'b0;
    #1 chk("arst_irq", 8'(irq), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    src = 3'b000;
    repeat (4) @(negedge clk);
    rd(2'd0, rv);
    chk("arst_ie", rv, 8'h00);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller directly upstream of the CPU's interrupt_0..interrupt_2 inputs.
- Synchronises raw peripheral/external interrupt sources.
- Detects rising edges or levels per source, latches pending bits, applies an enable mask and drives registered request lines to the CPU.
- Software accesses it over the CPU data/IO bus: address, 8-bit write data, write enable, read enable.

Parameters:
- N_SRC, 3, number of interrupt sources (1..8); irq_o[i] connects to CPU interrupt_i.
- BASE_ADDR, 16'hFF10, bus address of register 0; the block decodes BASE_ADDR+0..BASE_ADDR+3.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- src_i  in  N_SRC  raw interrupt sources, asynchronous to clk
- addr_i  in  16  bus address (dMemIOAddress)
- wr_data_i  in  8  bus write data from CPU
- wr_en_i  in  1  bus write strobe
- rd_en_i  in  1  bus read strobe
- rd_data_o  out  8  read data, valid the cycle after rd_en_i; 0 when not selected, so it is OR-able onto the bus
- irq_o  out  N_SRC  interrupt requests to the CPU, active high

Behaviour:
- Reset:
  - Async assert clears sync flops, edge history, IE, IP, IM, irq_o and rd_data_o to 0.
  - Deassertion is synchronised externally; the block only needs async clear.
- Register map (offset from BASE_ADDR), bits [N_SRC-1:0]:
  - Upper bits read 0; writes to them are ignored.
  - 0 IE (R/W): enable mask.
  - 1 IP (R, write-1-to-clear): pending.
  - 2 IM (R/W): per-source mode, 1 = rising-edge, 0 = level.
  - 3 RAW (RO): synchronised source levels.
  - Writes to RAW and to unmapped addresses are ignored.
- Synchroniser: two flops per source (s1, s2), then one history flop s3.
  - rise[i] = s2[i] & ~s3[i].
- Pending update each clock, per source:
  - set = IM ? rise : s2.
  - clr = write to offset 1 with wr_data_i[i] = 1.
  - IP_next = set | (IP & ~clr).
  - Set wins over a simultaneous clear.
  - A level-mode source held high cannot be cleared.
- IM change: takes effect the next clock. Switching to edge mode does not create a rise if s3 is already high.
- Output: irq_o <= IP & IE, registered.
  - Disabling a source drops irq_o the cycle after the IE write; IP is retained.
  - Re-enabling raises irq_o again one cycle later.
- Latency:
  - src_i rises before clock edge E1; s2 is high after E2; IP is set at E3; irq_o is high after E4.
  - W1C written at edge Ew: IP clears at Ew and irq_o falls at Ew+1.
- Reads: on rd_en_i with addr_i in range, rd_data_o <= register at the next edge; otherwise rd_data_o <= 0.
  - Read and write to the same address in the same cycle return the pre-write value.
- Writes with addr_i outside BASE_ADDR..BASE_ADDR+3 have no effect.
- Simultaneous events:
  - Multiple sources are independent; no priority encoding. The CPU prioritises.
  - A write plus a source edge in the same cycle follows the set-wins rule.
- Reset mid-operation: all pending state is lost and irq_o drops immediately (async).
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 with src_i=3'b111 and clocks running -> irq_o=0 and rd_data_o=0; after release, read IP -> 0x00.
- Edge mode:
  - Write IM=0x01 and IE=0x01.
  - Pulse src_i[0] high for 1 clk -> irq_o[0]=1 four edges after the rise; it stays 1 after src_i falls.
  - Write 0x01 to offset 1 -> irq_o[0]=0 one edge later; read IP -> 0x00.
- Level mode, held high:
  - IM=0, IE=0x02, src_i[1] held high; write W1C 0x02 -> IP[1] stays 1 and irq_o[1] stays 1.
  - Drop src_i[1], then W1C -> IP reads 0x00.
- Masking:
  - IE=0, source 2 edge -> IP reads 0x04 and irq_o=0.
  - Write IE=0x04 -> irq_o[2]=1 one edge after the write.
- Simultaneous set/clear: src_i[0] rise timed so IP set coincides with the W1C cycle (IM=1) -> IP[0] remains 1.
- Bus decode:
  - Write 0xFF to BASE_ADDR+4 and BASE_ADDR-1 -> IE, IP and IM unchanged.
  - Read BASE_ADDR+4 -> rd_data_o=0.
  - Read RAW with src_i=3'b101 stable -> 0x05; upper bits 0.
